// File: rtl/connect_four_renderer.sv
// Connect-four board renderer: maps the VGA raster position to a pixel colour
// through a two-stage pipeline, and animates a falling piece and blinking
// winning cells on frame boundaries.
module connect_four_renderer #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int CELL_LOG2    = 5,
    parameter int ORIGIN_X     = 192,
    parameter int ORIGIN_Y     = 112,
    parameter int RADIUS       = 14,
    parameter int FALL_STEP    = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                       clk_25MHz,
    input  logic                       rst,
    input  logic [9:0]                 h_count,
    input  logic [9:0]                 v_count,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic [2*ROWS*COLS-1:0]     board,
    input  logic [ROWS*COLS-1:0]       win_mask,
    input  logic [$clog2(COLS)-1:0]    current_col,
    input  logic [1:0]                 current_player,
    input  logic                       game_over,
    input  logic                       drop_start,
    input  logic [$clog2(COLS)-1:0]    drop_col,
    input  logic [$clog2(ROWS)-1:0]    drop_row,
    input  logic [1:0]                 drop_player,
    output logic                       drop_busy,
    output logic                       drop_done,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic [1:0]                 vga_r,
    output logic [1:0]                 vga_g,
    output logic [1:0]                 vga_b
);

    localparam int CW         = $clog2(COLS);
    localparam int RW         = $clog2(ROWS);
    localparam int CELL       = 1 << CELL_LOG2;
    localparam int HALF       = CELL / 2;
    localparam int BOARD_W    = COLS * CELL;
    localparam int BOARD_H    = ROWS * CELL;
    // Cursor cell sits one cell tall, leaving a 16 px gap above the board.
    localparam int CURSOR_OFS = 16 + CELL;
    localparam int BW         = $clog2(BLINK_FRAMES + 1);
    // Squared-distance width: offsets are CELL_LOG2+1 bits signed.
    localparam int DW         = CELL_LOG2 + 1;
    localparam int SW         = 2 * CELL_LOG2 + 2;

    // Colours packed as {r,g,b}
    localparam logic [5:0] C_BLACK = 6'b00_00_00;
    localparam logic [5:0] C_BG    = 6'b01_11_01;
    localparam logic [5:0] C_BLUE  = 6'b00_00_11;
    localparam logic [5:0] C_P1    = 6'b11_11_00;
    localparam logic [5:0] C_P2    = 6'b11_00_00;
    localparam logic [5:0] C_WHITE = 6'b11_11_11;

    typedef enum logic [1:0] {IDLE, FALL, DONE} anim_state_t;

    function automatic logic in_circle(input logic [CELL_LOG2-1:0] ox,
                                       input logic [CELL_LOG2-1:0] oy);
        logic signed [DW-1:0] dx, dy;
        logic signed [SW-1:0] dxe, dye, sq;
        dx  = $signed({1'b0, ox}) - $signed(DW'(HALF));
        dy  = $signed({1'b0, oy}) - $signed(DW'(HALF));
        dxe = SW'(dx);
        dye = SW'(dy);
        sq  = dxe * dxe + dye * dye;
        return sq <= $signed(SW'(RADIUS * RADIUS));
    endfunction

    function automatic logic [5:0] player_colour(input logic [1:0] p);
        case (p)
            2'b01:   return C_P1;
            2'b10:   return C_P2;
            default: return C_BG;
        endcase
    endfunction

    // ---------------- frame tick / blink ----------------
    logic          frame_tick;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    assign frame_tick = (h_count == 10'd0) && (v_count == 10'd480);

    // Count frames; each wrap flips the blink phase.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- drop animation FSM ----------------
    anim_state_t   state_q, state_d;
    logic [10:0]   fall_y, fall_y_d, fall_target;
    logic [11:0]   fall_sum;
    logic [CW-1:0] lat_col, lat_col_d;
    logic [RW-1:0] lat_row, lat_row_d, inv_row;
    logic [1:0]    lat_player, lat_player_d;

    assign inv_row     = RW'(ROWS - 1) - lat_row;
    assign fall_target = 11'(inv_row) << CELL_LOG2;
    assign drop_busy   = (state_q != IDLE);
    assign drop_done   = (state_q == DONE);

    // Animation state and latched request.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fall_y     <= '0;
            lat_col    <= '0;
            lat_row    <= '0;
            lat_player <= '0;
        end else begin
            state_q    <= state_d;
            fall_y     <= fall_y_d;
            lat_col    <= lat_col_d;
            lat_row    <= lat_row_d;
            lat_player <= lat_player_d;
        end
    end

    // Next state: the saturation check happens only on a frame tick, so a
    // drop into the top row still spends one frame falling.
    always_comb begin
        state_d      = state_q;
        fall_y_d     = fall_y;
        lat_col_d    = lat_col;
        lat_row_d    = lat_row;
        lat_player_d = lat_player;
        fall_sum     = 12'(fall_y) + 12'(FALL_STEP);
        case (state_q)
            IDLE: begin
                if (drop_start) begin
                    state_d      = FALL;
                    lat_col_d    = drop_col;
                    lat_row_d    = drop_row;
                    lat_player_d = drop_player;
                    fall_y_d     = '0;
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (fall_sum >= 12'(fall_target)) begin
                        fall_y_d = fall_target;
                        state_d  = DONE;
                    end else begin
                        fall_y_d = fall_sum[10:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- pixel stage 1: geometry ----------------
    logic signed [11:0]    hx, vy, cy, fy;
    logic                  col_ok, in_board, in_cursor, in_fall, is_target, active;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [CELL_LOG2-1:0]  off_y;

    assign hx        = $signed({2'b00, h_count}) - $signed(12'(ORIGIN_X));
    assign vy        = $signed({2'b00, v_count}) - $signed(12'(ORIGIN_Y));
    assign cy        = vy + $signed(12'(CURSOR_OFS));
    assign fy        = vy - $signed({1'b0, fall_y});
    assign col       = hx[CELL_LOG2 +: CW];
    assign row       = RW'(ROWS - 1) - vy[CELL_LOG2 +: RW];
    assign active    = (h_count < 10'd640) && (v_count < 10'd480);
    assign col_ok    = (hx >= 12'sd0) && (hx < $signed(12'(BOARD_W)));
    assign in_board  = col_ok && (vy >= 12'sd0) && (vy < $signed(12'(BOARD_H)));
    assign in_cursor = col_ok && (cy >= 12'sd0) && (cy < $signed(12'(CELL)))
                       && (col == current_col);
    assign in_fall   = (state_q == FALL) && in_board && (col == lat_col)
                       && (fy >= 12'sd0) && (fy < $signed(12'(CELL)));
    assign is_target = (state_q == FALL) && (row == lat_row) && (col == lat_col);
    assign off_y     = in_board ? vy[CELL_LOG2-1:0] : cy[CELL_LOG2-1:0];

    logic                 s1_active, s1_in_board, s1_in_cursor, s1_in_fall, s1_target;
    logic [CW-1:0]        s1_col;
    logic [RW-1:0]        s1_row;
    logic [CELL_LOG2-1:0] s1_off_x, s1_off_y, s1_fall_off_y;
    logic                 s1_hs, s1_vs;

    // Register the cell coordinates, region flags and in-cell offsets.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            s1_active     <= 1'b0;
            s1_in_board   <= 1'b0;
            s1_in_cursor  <= 1'b0;
            s1_in_fall    <= 1'b0;
            s1_target     <= 1'b0;
            s1_col        <= '0;
            s1_row        <= '0;
            s1_off_x      <= '0;
            s1_off_y      <= '0;
            s1_fall_off_y <= '0;
            s1_hs         <= 1'b1;
            s1_vs         <= 1'b1;
        end else begin
            s1_active     <= active;
            s1_in_board   <= in_board;
            s1_in_cursor  <= in_cursor;
            s1_in_fall    <= in_fall;
            s1_target     <= is_target;
            s1_col        <= col;
            s1_row        <= row;
            s1_off_x      <= hx[CELL_LOG2-1:0];
            s1_off_y      <= off_y;
            s1_fall_off_y <= fy[CELL_LOG2-1:0];
            s1_hs         <= hsync_in;
            s1_vs         <= vsync_in;
        end
    end

    // ---------------- pixel stage 2: colour ----------------
    int         cell_idx;
    logic [1:0] cell_val;
    logic       cell_win;
    logic [5:0] colour_d;

    // Colour priority: blanking, falling piece, board cell, cursor, background.
    always_comb begin
        colour_d = C_BG;
        cell_idx = int'(s1_row) * COLS + int'(s1_col);
        cell_val = s1_target ? 2'b00 : board[2*cell_idx +: 2];
        cell_win = win_mask[cell_idx];
        if (!s1_active) begin
            colour_d = C_BLACK;
        end else if (s1_in_board) begin
            if (s1_in_fall && in_circle(s1_off_x, s1_fall_off_y)) begin
                colour_d = player_colour(lat_player);
            end else if (in_circle(s1_off_x, s1_off_y)) begin
                if (game_over && cell_win && blink_phase)
                    colour_d = C_WHITE;
                else
                    colour_d = player_colour(cell_val);
            end else begin
                colour_d = C_BLUE;
            end
        end else if (s1_in_cursor) begin
            if (!game_over && in_circle(s1_off_x, s1_off_y))
                colour_d = player_colour(current_player);
        end
    end

    // Output register, syncs kept aligned with the colour.
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            {vga_r, vga_g, vga_b} <= C_BLACK;
            vga_hsync             <= 1'b1;
            vga_vsync             <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= colour_d;
            vga_hsync             <= s1_hs;
            vga_vsync             <= s1_vs;
        end
    end

endmodule
